mru_req_sched: RTL and testbench
================================

Name: mru_req_sched

Overview:
- Scheduler between two requesters and the shared MRU value buffer.
- The set requester pushes new 16-bit values; the get requester fetches an entry by index for 7-seg BCD display.
- Pends single-cycle requests and arbitrates round-robin.
- Drives the buffer's level-sensitive set/get strobes, bcd_rdy handshake and busy/valid tracking, with a timeout guard.

Parameters:
DATA_W, 16, width of a set value
IDX_W, 3, width of a get index (buffer of 8)
OUT_W, 20, width of buffer read data ({count, value} packed result)
TIMEOUT, 1024, max cycles to wait for any buffer handshake edge; must be >= buffer rate-limit count + 4

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
set_req  in  1  one-cycle pulse: push set_data
set_data  in  DATA_W  value, sampled with set_req
set_ack  out  1  one-cycle pulse: set completed
get_req  in  1  one-cycle pulse: read entry get_idx
get_idx  in  IDX_W  index, sampled with get_req
get_ack  out  1  one-cycle pulse: get_data valid
get_data  out  OUT_W  last read result, held until next get_ack
mru_set_o  out  1  level set strobe to buffer
mru_get_o  out  1  level get strobe to buffer
mru_data_o  out  DATA_W  operand to buffer (value, or zero-extended index)
mru_bcd_rdy_o  out  1  read-consumed handshake to buffer
mru_busy_i  in  1  buffer busy
mru_valid_i  in  1  buffer read data valid
mru_data_i  in  OUT_W  buffer read data
sched_busy_o  out  1  high whenever state != IDLE
timeout_o  out  1  one-cycle pulse: operation aborted by timeout

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; pend flags 0; timer 0; last_grant=GET, so SET wins the first tie.
- Pending:
  - set_req sets set_pend and loads set_buf; get_req sets get_pend and loads get_buf.
  - A new req while its own pend is set overwrites the buffer (latest wins), no error.
  - Requests are accepted in every state, including the cycle a grant clears the same pend: the new request re-pends.
- IDLE:
  - If any pend is set, grant: sole pending wins; if both pending, grant the type != last_grant.
  - On grant: clear that pend, copy operand to op_reg, update last_grant, timer=0, go ISSUE. IDLE to ISSUE takes 1 cycle.
- ISSUE:
  - Drive mru_set_o or mru_get_o=1 (never both) and mru_data_o=op_reg. Strobe held level until mru_busy_i=1.
  - SET: on mru_busy_i=1, drop strobe, go WAIT_SET.
  - GET: on mru_busy_i=1 and mru_valid_i=1 in the same cycle, capture mru_data_i into get_data, drop strobe, go RDY. Busy without valid keeps waiting.
- WAIT_SET: strobes 0; on mru_busy_i=0, pulse set_ack, go IDLE.
- RDY: assert mru_bcd_rdy_o; hold until mru_busy_i=0, then drop it, pulse get_ack (get_data already stable), go IDLE.
- mru_data_o stays 0 outside ISSUE.
- Timeout:
  - Timer resets on each state entry and counts in ISSUE/WAIT_SET/RDY.
  - When timer reaches TIMEOUT-1: drop all strobes and bcd_rdy, pulse timeout_o, no ack, go IDLE.
  - get_data is not updated on a timed-out get.
- sched_busy_o is combinational from state.
- set_ack, get_ack and timeout_o are mutually exclusive, each exactly 1 cycle.
- Timer width is clog2(TIMEOUT)+1, saturating never reached.

Test Plan:
- Set path: set_req with set_data=16'h1234; buffer model raises busy 3 cycles later and drops it 2 cycles after that -> mru_set_o high 4 cycles with mru_data_o=16'h1234; set_ack 1 cycle after busy falls; mru_get_o never high.
- Get path: get_req with idx=5; model returns busy+valid with 20'h3_0042 -> get_data=20'h30042; mru_bcd_rdy_o held until busy=0; get_ack pulse; mru_data_o=16'h0005 during ISSUE.
- Simultaneous: set_req and get_req both in the first cycle after reset -> SET granted first, GET second. Repeat both -> GET first, alternating.
- Overwrite: two set_reqs (0x00AA then 0x00BB) while a get is in flight -> exactly one set issued, with 0x00BB.
- Timeout: model never raises busy, TIMEOUT=16 -> strobe high 16 cycles, then timeout_o pulse, no ack, state IDLE, get_data unchanged.
- Reset mid-RDY: assert rst while mru_bcd_rdy_o=1 -> all outputs 0 asynchronously; after release a pending get_req is serviced normally.

Source files
------------

// File: rtl/mru_req_sched.sv
// mru_req_sched: pends single-cycle set/get requests, arbitrates them round-robin
// and runs the strobe / busy / valid / bcd_rdy handshake to the shared MRU buffer.
module mru_req_sched #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned OUT_W   = 20,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_req,
  input  logic [DATA_W-1:0] set_data,
  output logic              set_ack,
  input  logic              get_req,
  input  logic [IDX_W-1:0]  get_idx,
  output logic              get_ack,
  output logic [OUT_W-1:0]  get_data,
  output logic              mru_set_o,
  output logic              mru_get_o,
  output logic [DATA_W-1:0] mru_data_o,
  output logic              mru_bcd_rdy_o,
  input  logic              mru_busy_i,
  input  logic              mru_valid_i,
  input  logic [OUT_W-1:0]  mru_data_i,
  output logic              sched_busy_o,
  output logic              timeout_o
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SET = 2'd2,
    RDY      = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;

  logic              set_pend;
  logic              get_pend;
  logic [DATA_W-1:0] set_buf;
  logic [IDX_W-1:0]  get_buf;
  logic              last_get;
  logic [DATA_W-1:0] op_reg;
  logic              op_is_get;
  logic [TMR_W-1:0]  timer;
  logic [OUT_W-1:0]  rd_reg;

  logic              grant_set;
  logic              grant_get;
  logic              timed_out;

  logic [DATA_W-1:0] op_n;
  logic              op_get_n;
  logic              mru_set_n;
  logic              mru_get_n;
  logic [DATA_W-1:0] mru_data_n;
  logic              bcd_rdy_n;
  logic              set_ack_n;
  logic              get_ack_n;
  logic              timeout_n;
  logic              capture;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: round-robin grant in IDLE, handshake edges and timeout elsewhere
  always_comb begin
    state_n   = state;
    grant_set = 1'b0;
    grant_get = 1'b0;
    timed_out = (state != IDLE) && (timer == TMR_LAST);
    case (state)
      IDLE: begin
        if (set_pend && (!get_pend || last_get)) begin
          grant_set = 1'b1;
        end else if (get_pend) begin
          grant_get = 1'b1;
        end
        if (grant_set || grant_get) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (timed_out) begin
          state_n = IDLE;
        end else if (!op_is_get && mru_busy_i) begin
          state_n = WAIT_SET;
        end else if (op_is_get && mru_busy_i && mru_valid_i) begin
          state_n = RDY;
        end
      end
      WAIT_SET: begin
        if (timed_out || !mru_busy_i) begin
          state_n = IDLE;
        end
      end
      RDY: begin
        if (timed_out || !mru_busy_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs, aligned with state_n
  always_comb begin
    op_n       = op_reg;
    op_get_n   = op_is_get;
    mru_set_n  = 1'b0;
    mru_get_n  = 1'b0;
    mru_data_n = '0;
    bcd_rdy_n  = 1'b0;
    set_ack_n  = 1'b0;
    get_ack_n  = 1'b0;
    timeout_n  = timed_out;
    capture    = 1'b0;
    if (grant_set) begin
      op_n     = set_buf;
      op_get_n = 1'b0;
    end else if (grant_get) begin
      op_n     = DATA_W'(get_buf);
      op_get_n = 1'b1;
    end
    if (state_n == ISSUE) begin
      mru_set_n  = !op_get_n;
      mru_get_n  = op_get_n;
      mru_data_n = op_n;
    end
    bcd_rdy_n = (state_n == RDY);
    set_ack_n = (state == WAIT_SET) && (state_n == IDLE) && !timed_out;
    get_ack_n = (state == RDY) && (state_n == IDLE) && !timed_out;
    capture   = (state == ISSUE) && (state_n == RDY);
  end

  // Pending requests, operand/result holding, timer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_pend      <= 1'b0;
      get_pend      <= 1'b0;
      set_buf       <= '0;
      get_buf       <= '0;
      last_get      <= 1'b1;
      op_reg        <= '0;
      op_is_get     <= 1'b0;
      timer         <= '0;
      rd_reg        <= '0;
      get_data      <= '0;
      mru_set_o     <= 1'b0;
      mru_get_o     <= 1'b0;
      mru_data_o    <= '0;
      mru_bcd_rdy_o <= 1'b0;
      set_ack       <= 1'b0;
      get_ack       <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      // A request in the grant cycle re-pends with the new operand
      if (set_req) begin
        set_pend <= 1'b1;
        set_buf  <= set_data;
      end else if (grant_set) begin
        set_pend <= 1'b0;
      end
      if (get_req) begin
        get_pend <= 1'b1;
        get_buf  <= get_idx;
      end else if (grant_get) begin
        get_pend <= 1'b0;
      end
      if (grant_set) begin
        last_get <= 1'b0;
      end else if (grant_get) begin
        last_get <= 1'b1;
      end
      op_reg    <= op_n;
      op_is_get <= op_get_n;

      if ((state_n != state) || (state == IDLE)) begin
        timer <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end

      // Read data is only published on get_ack, so a timed-out get leaves get_data alone
      if (capture) begin
        rd_reg <= mru_data_i;
      end
      if (get_ack_n) begin
        get_data <= rd_reg;
      end

      mru_set_o     <= mru_set_n;
      mru_get_o     <= mru_get_n;
      mru_data_o    <= mru_data_n;
      mru_bcd_rdy_o <= bcd_rdy_n;
      set_ack       <= set_ack_n;
      get_ack       <= get_ack_n;
      timeout_o     <= timeout_n;
    end
  end

  assign sched_busy_o = (state != IDLE);

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    !(mru_set_o && mru_get_o));
  a_done_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({set_ack, get_ack, timeout_o}));

endmodule

// File: tb/tb_mru_req_sched.sv
// Directed bench for mru_req_sched with a small behavioural MRU buffer model.
module tb_mru_req_sched;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned OUT_W   = 20;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              set_req;
  logic [DATA_W-1:0] set_data;
  logic              set_ack;
  logic              get_req;
  logic [IDX_W-1:0]  get_idx;
  logic              get_ack;
  logic [OUT_W-1:0]  get_data;
  logic              mru_set_o;
  logic              mru_get_o;
  logic [DATA_W-1:0] mru_data_o;
  logic              mru_bcd_rdy_o;
  logic              mru_busy_i;
  logic              mru_valid_i;
  logic [OUT_W-1:0]  mru_data_i;
  logic              sched_busy_o;
  logic              timeout_o;

  mru_req_sched #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .OUT_W  (OUT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .set_req      (set_req),
    .set_data     (set_data),
    .set_ack      (set_ack),
    .get_req      (get_req),
    .get_idx      (get_idx),
    .get_ack      (get_ack),
    .get_data     (get_data),
    .mru_set_o    (mru_set_o),
    .mru_get_o    (mru_get_o),
    .mru_data_o   (mru_data_o),
    .mru_bcd_rdy_o(mru_bcd_rdy_o),
    .mru_busy_i   (mru_busy_i),
    .mru_valid_i  (mru_valid_i),
    .mru_data_i   (mru_data_i),
    .sched_busy_o (sched_busy_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Buffer model: busy rises on the 4th strobe cycle, held for 2 cycles
  // (for a get, 2 cycles of bcd_rdy), valid+data with busy on a get.
  logic             model_hang;
  logic [OUT_W-1:0] m_rdata;
  int               m_cnt;
  int               m_hold;
  logic             m_set_op;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mru_busy_i  = 1'b0;
      mru_valid_i = 1'b0;
      mru_data_i  = '0;
      m_cnt       = 0;
      m_hold      = 0;
      m_set_op    = 1'b0;
    end else if (!mru_busy_i) begin
      if ((mru_set_o || mru_get_o) && !model_hang) begin
        m_cnt++;
        if (m_cnt == 4) begin
          mru_busy_i  = 1'b1;
          mru_valid_i = mru_get_o;
          mru_data_i  = m_rdata;
          m_set_op    = mru_set_o;
          m_cnt       = 0;
          m_hold      = 0;
        end
      end else begin
        m_cnt = 0;
      end
    end else begin
      if (m_set_op || mru_bcd_rdy_o) m_hold++;
      if (m_hold == 2) begin
        mru_busy_i  = 1'b0;
        mru_valid_i = 1'b0;
      end
    end
  end

  // Monitor: strobe/rdy cycle counts, issued operations, protocol violations
  int               n_set_hi = 0;
  int               n_get_hi = 0;
  int               n_rdy_hi = 0;
  int               n_both   = 0;
  int               n_dbad   = 0;
  int               n_excl   = 0;
  logic             prev_strb = 1'b0;
  logic             op_type[$];
  logic [DATA_W-1:0] op_data[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mru_set_o) n_set_hi++;
      if (mru_get_o) n_get_hi++;
      if (mru_bcd_rdy_o) n_rdy_hi++;
      if (mru_set_o && mru_get_o) n_both++;
      if (!mru_set_o && !mru_get_o && mru_data_o != '0) n_dbad++;
      if ((int'(set_ack) + int'(get_ack) + int'(timeout_o)) > 1) n_excl++;
      if ((mru_set_o || mru_get_o) && !prev_strb) begin
        op_type.push_back(mru_get_o);
        op_data.push_back(mru_data_o);
      end
      prev_strb = mru_set_o || mru_get_o;
    end
  end

  // Called at a negedge; request is seen at the following posedge
  task automatic pulse(input logic s, input logic [DATA_W-1:0] sd,
                       input logic g, input logic [IDX_W-1:0] gi);
    set_req  = s;
    set_data = sd;
    get_req  = g;
    get_idx  = gi;
    @(negedge clk);
    set_req = 1'b0;
    get_req = 1'b0;
  endtask

  // ev = {timeout_o, get_ack, set_ack} of the first completion seen, 0 if none
  task automatic wait_end(input int limit, output logic [2:0] ev, output int cyc);
    ev  = '0;
    cyc = 0;
    while (ev == 3'b000 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      ev = {timeout_o, get_ack, set_ack};
    end
  endtask

  logic [2:0] ev;
  int         cyc;
  int         b_set;
  int         b_get;
  int         b_rdy;
  int         b_op;

  task automatic snap();
    b_set = n_set_hi;
    b_get = n_get_hi;
    b_rdy = n_rdy_hi;
    b_op  = op_type.size();
  endtask

  initial begin
    rst        = 1'b1;
    set_req    = 1'b0;
    set_data   = '0;
    get_req    = 1'b0;
    get_idx    = '0;
    model_hang = 1'b0;
    m_rdata    = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ctl", {set_ack, get_ack, mru_set_o, mru_get_o, mru_bcd_rdy_o, sched_busy_o, timeout_o}, '0);
    chk("rst_gdata", get_data, '0);
    chk("rst_mdata", mru_data_o, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", sched_busy_o, 1'b0);

    // Simultaneous requests, then a second pair while the first set is in flight
    snap();
    pulse(1'b1, 16'h0111, 1'b1, 3'd2);
    @(negedge clk);
    @(negedge clk);
    pulse(1'b1, 16'h0222, 1'b1, 3'd4);
    wait_end(40, ev, cyc);
    chk("sim_ev1", ev, 3'b001);
    wait_end(40, ev, cyc);
    chk("sim_ev2", ev, 3'b010);
    wait_end(40, ev, cyc);
    chk("sim_ev3", ev, 3'b001);
    chk("sim_nops", op_type.size() - b_op, 3);
    if (op_type.size() - b_op == 3) begin
      chk("sim_op0", {op_type[b_op], op_data[b_op]}, {1'b0, 16'h0111});
      chk("sim_op1", {op_type[b_op+1], op_data[b_op+1]}, {1'b1, 16'h0004});
      chk("sim_op2", {op_type[b_op+2], op_data[b_op+2]}, {1'b0, 16'h0222});
    end
    @(negedge clk);

    // Set path
    snap();
    pulse(1'b1, 16'h1234, 1'b0, 3'd0);
    wait_end(40, ev, cyc);
    chk("set_ev", ev, 3'b001);
    chk("set_lat", cyc, 7);
    chk("set_hi", n_set_hi - b_set, 4);
    chk("set_gethi", n_get_hi - b_get, 0);
    chk("set_data", op_data[op_data.size()-1], 16'h1234);
    chk("set_idle", sched_busy_o, 1'b0);
    @(negedge clk);
    chk("set_ack_1cyc", set_ack, 1'b0);

    // Get path
    snap();
    m_rdata = 20'h3_0042;
    pulse(1'b0, 16'h0000, 1'b1, 3'd5);
    wait_end(40, ev, cyc);
    chk("get_ev", ev, 3'b010);
    chk("get_lat", cyc, 7);
    chk("get_data", get_data, 20'h3_0042);
    chk("get_rdy_hi", n_rdy_hi - b_rdy, 2);
    chk("get_hi", n_get_hi - b_get, 4);
    chk("get_sethi", n_set_hi - b_set, 0);
    chk("get_idx", op_data[op_data.size()-1], 16'h0005);
    @(negedge clk);
    chk("get_ack_1cyc", get_ack, 1'b0);
    chk("get_rdy_off", mru_bcd_rdy_o, 1'b0);

    // Overwrite: two sets while a get is in flight collapse into one
    snap();
    m_rdata = 20'h1_2345;
    pulse(1'b0, 16'h0000, 1'b1, 3'd1);
    @(negedge clk);
    pulse(1'b1, 16'h00AA, 1'b0, 3'd0);
    pulse(1'b1, 16'h00BB, 1'b0, 3'd0);
    wait_end(40, ev, cyc);
    chk("ovw_ev1", ev, 3'b010);
    wait_end(40, ev, cyc);
    chk("ovw_ev2", ev, 3'b001);
    wait_end(20, ev, cyc);
    chk("ovw_none", ev, 3'b000);
    chk("ovw_nops", op_type.size() - b_op, 2);
    if (op_type.size() - b_op == 2) begin
      chk("ovw_op1", {op_type[b_op+1], op_data[b_op+1]}, {1'b0, 16'h00BB});
    end
    chk("ovw_gdata", get_data, 20'h1_2345);

    // Timeout: buffer never answers
    snap();
    model_hang = 1'b1;
    m_rdata    = 20'hF_FFFF;
    pulse(1'b0, 16'h0000, 1'b1, 3'd7);
    wait_end(40, ev, cyc);
    chk("tmo_ev", ev, 3'b100);
    chk("tmo_lat", cyc, 17);
    chk("tmo_hi", n_get_hi - b_get, 16);
    chk("tmo_gdata", get_data, 20'h1_2345);
    chk("tmo_idle", sched_busy_o, 1'b0);
    chk("tmo_strb", {mru_set_o, mru_get_o, mru_bcd_rdy_o}, 3'b000);
    @(negedge clk);
    chk("tmo_1cyc", timeout_o, 1'b0);
    model_hang = 1'b0;

    // Reset in the middle of RDY, then a fresh get
    m_rdata = 20'hA_BCDE;
    pulse(1'b0, 16'h0000, 1'b1, 3'd3);
    cyc = 0;
    while (!mru_bcd_rdy_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_rdy_seen", mru_bcd_rdy_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {set_ack, get_ack, mru_set_o, mru_get_o, mru_bcd_rdy_o, sched_busy_o, timeout_o}, '0);
    chk("mid_rst_gdata", get_data, '0);
    chk("mid_rst_mdata", mru_data_o, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    snap();
    m_rdata = 20'h0_BEEF;
    pulse(1'b0, 16'h0000, 1'b1, 3'd6);
    wait_end(40, ev, cyc);
    chk("post_ev", ev, 3'b010);
    chk("post_lat", cyc, 7);
    chk("post_gdata", get_data, 20'h0_BEEF);
    chk("post_idx", op_data[op_data.size()-1], 16'h0006);

    // Whole-run protocol checks
    chk("never_both", n_both, 0);
    chk("mdata_zero", n_dbad, 0);
    chk("done_excl", n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
